ahb_arbiter_n: RTL and testbench

AHB_ARBITER_N -- requirements
Module: ahb_arbiter_n

---
 rtl/ahb_arb_pkg.sv | 21 ++
 rtl/rr_pick.sv | 43 ++++
 rtl/ahb_arbiter_n.sv | 154 +++++++++++++++
 tb/tb_ahb_arbiter_n.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ahb_arb_pkg
// Description : Shared FSM state encoding and arbitration-mode constants for
//               the AHB N-master arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package ahb_arb_pkg;

    // Bus ownership states: no owner, or exactly one granted master.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_e;

    // Arbitration policies selectable through ARB_MODE.
    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

endpackage : ahb_arb_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational winner search. Scans the request vector upward
//               from a start index, wrapping at N, and returns the first set
//               position. A start of 0 gives plain lowest-index priority.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import ahb_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] start_i,
    output logic          valid_o,
    output logic [IW-1:0] idx_o
);

    // First requester at or after start_i in circular order.
    always_comb begin
        int            k;
        logic [IW-1:0] k_idx;
        valid_o = 1'b0;
        idx_o   = '0;
        k       = 0;
        k_idx   = '0;
        for (int i = 0; i < N; i++) begin
            k = int'(start_i) + i;
            if (k >= N) begin
                k = k - N;
            end
            k_idx = IW'(k);
            if (!valid_o && req_i[k_idx]) begin
                valid_o = 1'b1;
                idx_o   = k_idx;
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/ahb_arbiter_n.sv
`default_nettype none
// ============================================================================
// Module      : ahb_arbiter_n
// Description : AHB bus arbiter for NUM_MASTERS masters. Fixed-priority or
//               round-robin selection, locked sequences bounded by MAX_LOCK,
//               unconditional release on error, direct handover between
//               owners and registered grant/master/slave-select outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_arbiter_n
    import ahb_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int SEL_W       = 2,
    parameter int ARB_MODE    = 1,
    parameter int MAX_LOCK    = 4
) (
    input  logic                         hclk,
    input  logic                         hresetn,
    input  logic [NUM_MASTERS-1:0]       hreq,
    input  logic [NUM_MASTERS-1:0]       hlock,
    input  logic [NUM_MASTERS*SEL_W-1:0] sel_in,
    input  logic                         hready_out,
    input  logic                         hresp,
    output logic [NUM_MASTERS-1:0]       hgrant,
    output logic [$clog2(NUM_MASTERS)-1:0] hmaster,
    output logic [SEL_W-1:0]             sel,
    output logic                         bus_busy
);

    localparam int IDX_W = $clog2(NUM_MASTERS);
    // The lock counter only needs to reach MAX_LOCK-1; it saturates there.
    localparam int CNT_W = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;

    arb_state_e             state_q, state_d;
    logic [NUM_MASTERS-1:0] hgrant_q, hgrant_d;
    logic [IDX_W-1:0]       hmaster_q, hmaster_d;
    logic [IDX_W-1:0]       last_owner_q, last_owner_d;
    logic [SEL_W-1:0]       sel_q, sel_d;
    logic [CNT_W-1:0]       lock_cnt_q, lock_cnt_d;

    logic                   w_tr_done;
    logic                   w_tr_err;
    logic                   w_owner_locked;
    logic                   w_others_req;
    logic                   w_lock_limit;
    logic                   w_force_handover;
    logic [IDX_W-1:0]       w_start;
    logic [NUM_MASTERS-1:0] w_pick_req;
    logic                   w_pick_valid;
    logic [IDX_W-1:0]       w_pick_idx;
    logic [SEL_W-1:0]       w_owner_sel;
    logic [SEL_W-1:0]       w_winner_sel;
    logic                   w_release;

    assign w_tr_done      = hready_out & ~hresp;
    assign w_tr_err       = hready_out &  hresp;
    assign w_owner_locked = hlock[hmaster_q];
    assign w_others_req   = |(hreq & ~hgrant_q);
    assign w_lock_limit   = (MAX_LOCK > 0) && (lock_cnt_q == CNT_W'(MAX_LOCK - 1)) && w_others_req;

    // A locked owner that hits the limit must yield to the waiter, so it is
    // removed from the candidate set (matters for fixed priority).
    assign w_force_handover = (state_q == OWNED) && w_tr_done && w_owner_locked && w_lock_limit;
    assign w_pick_req       = hreq & ~(w_force_handover ? hgrant_q : '0);

    // Round-robin searches from the master after the last owner, so the
    // releasing owner is examined last; fixed priority always starts at 0.
    assign w_start = (ARB_MODE == ARB_RR)
                   ? ((last_owner_q == IDX_W'(NUM_MASTERS - 1)) ? '0 : last_owner_q + IDX_W'(1))
                   : '0;

    assign w_owner_sel  = SEL_W'(sel_in >> (int'(hmaster_q)  * SEL_W));
    assign w_winner_sel = SEL_W'(sel_in >> (int'(w_pick_idx) * SEL_W));

    rr_pick #(
        .N  (NUM_MASTERS),
        .IW (IDX_W)
    ) u_pick (
        .req_i   (w_pick_req),
        .start_i (w_start),
        .valid_o (w_pick_valid),
        .idx_o   (w_pick_idx)
    );

    // Next-state and next-output decode for the ownership FSM.
    always_comb begin
        state_d      = state_q;
        hgrant_d     = hgrant_q;
        hmaster_d    = hmaster_q;
        last_owner_d = last_owner_q;
        sel_d        = sel_q;
        lock_cnt_d   = lock_cnt_q;
        w_release    = 1'b0;

        if (state_q == OWNED) begin
            sel_d = w_owner_sel;
            if (w_tr_err) begin
                w_release = 1'b1;
            end else if (w_tr_done) begin
                if (!w_owner_locked || w_lock_limit) begin
                    w_release = 1'b1;
                end else if ((MAX_LOCK > 0) && (lock_cnt_q != CNT_W'(MAX_LOCK - 1))) begin
                    lock_cnt_d = lock_cnt_q + CNT_W'(1);
                end
            end
            if (!w_owner_locked) begin
                lock_cnt_d = '0;
            end
        end

        if ((state_q == IDLE) || w_release) begin
            lock_cnt_d = '0;
            if (w_pick_valid) begin
                state_d              = OWNED;
                hgrant_d             = '0;
                hgrant_d[w_pick_idx] = 1'b1;
                hmaster_d            = w_pick_idx;
                last_owner_d         = w_pick_idx;
                sel_d                = w_winner_sel;
            end else begin
                state_d  = IDLE;
                hgrant_d = '0;
                sel_d    = '0;
            end
        end
    end

    // State and output registers; reset drops any grant immediately.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q      <= IDLE;
            hgrant_q     <= '0;
            hmaster_q    <= '0;
            last_owner_q <= IDX_W'(NUM_MASTERS - 1);
            sel_q        <= '0;
            lock_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            hgrant_q     <= hgrant_d;
            hmaster_q    <= hmaster_d;
            last_owner_q <= last_owner_d;
            sel_q        <= sel_d;
            lock_cnt_q   <= lock_cnt_d;
        end
    end

    assign hgrant   = hgrant_q;
    assign hmaster  = hmaster_q;
    assign sel      = sel_q;
    assign bus_busy = |hgrant_q;

endmodule : ahb_arbiter_n
`default_nettype wire

// File: tb/tb_ahb_arbiter_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_arbiter_n
// Description : Testbench for ahb_arbiter_n. A round-robin and a fixed-priority
//               instance share the same inputs; each is compared every cycle
//               against a behavioural ownership model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_arbiter_n;

    localparam int N  = 4;
    localparam int SW = 2;
    localparam int ML = 4;

    logic          hclk       = 1'b0;
    logic          hresetn    = 1'b1;
    logic [N-1:0]  hreq       = '0;
    logic [N-1:0]  hlock      = '0;
    logic [N*SW-1:0] sel_in   = '0;
    logic          hready_out = 1'b0;
    logic          hresp      = 1'b0;

    logic [N-1:0]  g_fx, g_rr;
    logic [1:0]    m_fx, m_rr;
    logic [SW-1:0] s_fx, s_rr;
    logic          b_fx, b_rr;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state, indexed by ARB_MODE (0 = fixed, 1 = round-robin).
    int m_owner [2];
    int m_hm    [2];
    int m_last  [2];
    int m_ltx   [2];
    int m_sel   [2];

    always #5 hclk = ~hclk;

    ahb_arbiter_n #(.NUM_MASTERS(N), .SEL_W(SW), .ARB_MODE(0), .MAX_LOCK(ML)) dut_fx (
        .hclk(hclk), .hresetn(hresetn), .hreq(hreq), .hlock(hlock), .sel_in(sel_in),
        .hready_out(hready_out), .hresp(hresp),
        .hgrant(g_fx), .hmaster(m_fx), .sel(s_fx), .bus_busy(b_fx)
    );

    ahb_arbiter_n #(.NUM_MASTERS(N), .SEL_W(SW), .ARB_MODE(1), .MAX_LOCK(ML)) dut_rr (
        .hclk(hclk), .hresetn(hresetn), .hreq(hreq), .hlock(hlock), .sel_in(sel_in),
        .hready_out(hready_out), .hresp(hresp),
        .hgrant(g_rr), .hmaster(m_rr), .sel(s_rr), .bus_busy(b_rr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model_winner(input logic [N-1:0] cand, input int start);
        for (int i = 0; i < N; i++) begin
            if (cand[(start + i) % N]) return (start + i) % N;
        end
        return -1;
    endfunction

    function automatic int owner_sel(input int i);
        logic [SW-1:0] s;
        s = sel_in[i*SW +: SW];
        return int'(s);
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_owner[m] = -1;
            m_hm[m]    = 0;
            m_last[m]  = N - 1;
            m_ltx[m]   = 0;
            m_sel[m]   = 0;
        end
    endtask

    task automatic model_take(input int m, input int w);
        m_owner[m] = w;
        m_hm[m]    = w;
        m_last[m]  = w;
        m_ltx[m]   = 0;
        m_sel[m]   = owner_sel(w);
    endtask

    // One clock of the ownership rules, evaluated on the inputs now applied.
    task automatic model_step(input int m);
        int o, w;
        logic [N-1:0] cand;
        bit lk, others, rel;
        o = m_owner[m];
        if (o < 0) begin
            if (hreq != '0) model_take(m, model_winner(hreq, (m == 1) ? (m_last[m] + 1) % N : 0));
            return;
        end
        lk     = hlock[o];
        others = (hreq & ~(N'(1) << o)) != '0;
        rel    = 1'b0;
        cand   = hreq;
        if (hready_out && hresp) begin
            rel = 1'b1;
        end else if (hready_out && !lk) begin
            rel = 1'b1;
        end else if (hready_out) begin
            m_ltx[m]++;
            if (ML > 0 && m_ltx[m] >= ML && others) begin
                rel  = 1'b1;
                cand = hreq & ~(N'(1) << o);
            end
        end
        if (!lk) m_ltx[m] = 0;
        if (rel) begin
            m_ltx[m] = 0;
            w = model_winner(cand, (m == 1) ? (o + 1) % N : 0);
            if (w >= 0) begin
                model_take(m, w);
            end else begin
                m_owner[m] = -1;
                m_sel[m]   = 0;
            end
        end else begin
            m_sel[m] = owner_sel(o);
        end
    endtask

    function automatic logic [31:0] exp_grant(input int m);
        return (m_owner[m] < 0) ? 32'd0 : (32'd1 << m_owner[m]);
    endfunction

    task automatic compare_all();
        check("fx hgrant",   32'(g_fx), exp_grant(0));
        check("fx hmaster",  32'(m_fx), 32'(m_hm[0]));
        check("fx sel",      32'(s_fx), 32'(m_sel[0]));
        check("fx bus_busy", 32'(b_fx), 32'(m_owner[0] >= 0));
        check("rr hgrant",   32'(g_rr), exp_grant(1));
        check("rr hmaster",  32'(m_rr), 32'(m_hm[1]));
        check("rr sel",      32'(s_rr), 32'(m_sel[1]));
        check("rr bus_busy", 32'(b_rr), 32'(m_owner[1] >= 0));
    endtask

    // Advance one clock: update the model, then sample just after the edge.
    task automatic step();
        if (!hresetn) begin
            model_reset();
        end else begin
            model_step(0);
            model_step(1);
        end
        @(posedge hclk);
        #1;
        compare_all();
    endtask

    task automatic drain();
        hreq = '0; hlock = '0; hresp = 1'b0; hready_out = 1'b1;
        repeat (2) step();
        hready_out = 1'b0;
    endtask

    task automatic check_reset_now(input string tag);
        check({tag, " fx hgrant"},  32'(g_fx), 32'd0);
        check({tag, " fx sel"},     32'(s_fx), 32'd0);
        check({tag, " fx busy"},    32'(b_fx), 32'd0);
        check({tag, " rr hgrant"},  32'(g_rr), 32'd0);
        check({tag, " rr sel"},     32'(s_rr), 32'd0);
        check({tag, " rr hmaster"}, 32'(m_rr), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset before any clock edge must clear outputs asynchronously.
        #1 hresetn = 1'b0;
        #1 check_reset_now("reset");
        model_reset();
        sel_in = 8'($urandom);
        step();
        hresetn = 1'b1;
        step();

        // Round-robin rotation with every master requesting.
        hreq = 4'b1111;
        step();
        check("rot first", 32'(g_rr), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            sel_in = 8'($urandom);
            hready_out = 1'b0;
            step();
            check("rot hold", 32'(g_rr), 32'd1 << (k - 1));
            hready_out = 1'b1;
            step();
            check("rot next", 32'(g_rr), 32'd1 << (k % 4));
        end

        // Fixed priority: late higher-priority request waits for tr_done.
        drain();
        hreq = 4'b1010;
        step();
        check("fx first", 32'(g_fx), 32'b0010);
        hreq = 4'b1011;
        step();
        check("fx hold", 32'(g_fx), 32'b0010);
        hready_out = 1'b1;
        step();
        check("fx preempt", 32'(g_fx), 32'b0001);

        // Locked master 2 keeps the bus for MAX_LOCK transfers.
        drain();
        hreq = 4'b0100;
        step();
        hreq = 4'b0101; hlock = 4'b0100; hready_out = 1'b1;
        for (int k = 1; k <= ML; k++) begin
            step();
            check("lock fx", 32'(g_fx), (k < ML) ? 32'b0100 : 32'b0001);
            check("lock rr", 32'(g_rr), (k < ML) ? 32'b0100 : 32'b0001);
        end

        // Error response releases a locked owner, with and without a waiter.
        drain();
        hreq = 4'b0010;
        step();
        hreq = 4'b0011; hlock = 4'b0010; hready_out = 1'b1; hresp = 1'b1;
        step();
        check("err handover fx", 32'(g_fx), 32'b0001);
        check("err handover rr", 32'(g_rr), 32'b0001);
        drain();
        hreq = 4'b0010;
        step();
        hreq = 4'b0000; hlock = 4'b0010; hready_out = 1'b1; hresp = 1'b1;
        step();
        check("err idle rr", 32'(g_rr), 32'd0);
        check("err idle busy", 32'(b_rr), 32'd0);

        // Reset in the middle of master 3's tenure.
        drain();
        hreq = 4'b1000;
        step();
        check("pre-reset owner", 32'(g_rr), 32'b1000);
        hresetn = 1'b0;
        #2 check_reset_now("mid reset");
        step();
        hresetn = 1'b1;
        step();
        check("post-reset grant", 32'(g_rr), 32'b1000);
        check("post-reset hmaster", 32'(m_rr), 32'd3);

        // Owner's slave select follows its slice; other slices are ignored.
        drain();
        hreq = 4'b0100;
        step();
        for (int k = 0; k < 4; k++) begin
            sel_in = 8'($urandom);
            sel_in[2*SW +: SW] = 2'(k);
            step();
            check("sel follow", 32'(s_rr), 32'(k));
        end

        // Randomized traffic, including occasional asynchronous resets.
        for (int i = 0; i < 400; i++) begin
            hreq       = 4'($urandom);
            hlock      = ($urandom_range(0, 1) == 0) ? 4'($urandom) : 4'b0000;
            sel_in     = 8'($urandom);
            hready_out = ($urandom_range(0, 3) != 0);
            hresp      = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 59) == 0) begin
                hresetn = 1'b0;
                #2 check_reset_now("rand reset");
            end else begin
                hresetn = 1'b1;
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_ahb_arbiter_n
`default_nettype wire
